// File: rtl/sw_wavefront_array.sv
// Linear systolic Smith-Waterman matrix-fill engine: one PE per query row, one anti-diagonal per advance.
// Optional best-score tracking is compiled in with `define SW_MAX_TRACK_EN.
module sw_wavefront_array #(
  parameter int NUM_PE       = 16,
  parameter int DB_LENGTH    = 16,
  parameter int LETTER_WIDTH = 2,
  parameter int SCORE_WIDTH  = 8,
  parameter int MATCH        = 2,
  parameter int MISMATCH     = 1,
  parameter int GAP          = 1,
  localparam int DIAG_W = $clog2(NUM_PE + DB_LENGTH),
  localparam int ROW_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
  localparam int COL_W  = (DB_LENGTH > 1) ? $clog2(DB_LENGTH) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [NUM_PE*LETTER_WIDTH-1:0]    query_seq,
  input  logic [DB_LENGTH*LETTER_WIDTH-1:0] database_seq,
  output logic                              busy,
  output logic                              done,
  output logic                              pkt_valid,
  input  logic                              pkt_ready,
  output logic [DIAG_W-1:0]                 pkt_diag,
  output logic [NUM_PE-1:0]                 pkt_mask,
  output logic [NUM_PE*SCORE_WIDTH-1:0]     pkt_scores,
  output logic [NUM_PE*2-1:0]               pkt_src,
  output logic [SCORE_WIDTH-1:0]            max_score,
  output logic [ROW_W-1:0]                  max_row,
  output logic [COL_W-1:0]                  max_col
);

  localparam int SW = SCORE_WIDTH;
  localparam int LW = LETTER_WIDTH;
  localparam logic [DIAG_W-1:0] LAST_D = DIAG_W'(NUM_PE + DB_LENGTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input int b);
    logic [SW:0] s;
    s = {1'b0, a} + (SW+1)'(b);
    return s[SW] ? '1 : s[SW-1:0];
  endfunction

  function automatic logic [SW-1:0] sub_floor(input logic [SW-1:0] a, input int b);
    if (int'(a) > b) return a - SW'(b);
    return '0;
  endfunction

  state_t state, state_nxt;
  logic   load, adv, fin;

  logic [NUM_PE*LW-1:0]         query_q;
  logic [DB_LENGTH*LW-1:0]      db_q;
  logic [DIAG_W-1:0]            diag_cnt;
  logic [NUM_PE-1:0][SW-1:0]    h_p1, h_p2, h_new;
  logic [NUM_PE-1:0][1:0]       src_p1, src_new;
  logic [NUM_PE-1:0]            mask_p1, mask_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (!pkt_valid || pkt_ready) begin
        adv = 1'b1;
        if (diag_cnt == LAST_D) state_nxt = FLUSH;
      end
      FLUSH: if (pkt_valid && pkt_ready) begin
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: cell evaluation for diagonal diag_cnt from the p1/p2 wavefronts
  for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
    logic [SW-1:0] top_in, diag_in, d_term, t_term, l_term, h_cell;
    logic [1:0]    s_cell;
    logic [LW-1:0] db_letter;
    logic          act;
    int            j;

    if (i == 0) begin : g_edge
      assign top_in  = '0;
      assign diag_in = '0;
    end else begin : g_inner
      assign top_in  = h_p1[i-1];
      assign diag_in = h_p2[i-1];
    end

    always_comb begin
      act       = (int'(diag_cnt) >= i) && (int'(diag_cnt) - i < DB_LENGTH);
      j         = act ? int'(diag_cnt) - i : 0;
      db_letter = db_q[j*LW +: LW];
      d_term    = (query_q[i*LW +: LW] == db_letter) ? sat_add(diag_in, MATCH)
                                                     : sub_floor(diag_in, MISMATCH);
      t_term    = sub_floor(top_in, GAP);
      l_term    = sub_floor(h_p1[i], GAP);
      h_cell    = d_term;
      if (t_term > h_cell) h_cell = t_term;
      if (l_term > h_cell) h_cell = l_term;
      if (h_cell == '0)         s_cell = 2'b00;
      else if (h_cell == d_term) s_cell = 2'b01;
      else if (h_cell == t_term) s_cell = 2'b10;
      else                       s_cell = 2'b11;
      if (!act) begin
        h_cell = '0;
        s_cell = 2'b00;
      end
    end

    assign h_new[i]    = h_cell;
    assign src_new[i]  = s_cell;
    assign mask_new[i] = act;
  end

  // Stage p1: registered packet; h_p1/h_p2 double as the d-1/d-2 wavefronts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_diag  <= '0;
      diag_cnt  <= '0;
      query_q   <= '0;
      db_q      <= '0;
      h_p1      <= '0;
      h_p2      <= '0;
      src_p1    <= '0;
      mask_p1   <= '0;
    end else begin
      done <= fin;
      if (load) begin
        busy     <= 1'b1;
        query_q  <= query_seq;
        db_q     <= database_seq;
        diag_cnt <= '0;
        h_p1     <= '0;
        h_p2     <= '0;
        src_p1   <= '0;
        mask_p1  <= '0;
      end else if (adv) begin
        pkt_valid <= 1'b1;
        pkt_diag  <= diag_cnt;
        diag_cnt  <= diag_cnt + 1'b1;
        h_p2      <= h_p1;
        h_p1      <= h_new;
        src_p1    <= src_new;
        mask_p1   <= mask_new;
      end else if (fin) begin
        busy      <= 1'b0;
        pkt_valid <= 1'b0;
      end
    end
  end

  assign pkt_scores = h_p1;
  assign pkt_src    = src_p1;
  assign pkt_mask   = mask_p1;

`ifdef SW_MAX_TRACK_EN
  logic [SW-1:0]    best_score;
  logic [ROW_W-1:0] best_row;
  logic [COL_W-1:0] best_col;

  // Row-ascending strict compare keeps the earliest (lowest d, then row) on ties
  always_comb begin
    best_score = max_score;
    best_row   = max_row;
    best_col   = max_col;
    for (int i = 0; i < NUM_PE; i++) begin
      if (mask_new[i] && (h_new[i] > best_score)) begin
        best_score = h_new[i];
        best_row   = ROW_W'(i);
        best_col   = COL_W'(int'(diag_cnt) - i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_score <= '0;
      max_row   <= '0;
      max_col   <= '0;
    end else if (load) begin
      max_score <= '0;
      max_row   <= '0;
      max_col   <= '0;
    end else if (adv) begin
      max_score <= best_score;
      max_row   <= best_row;
      max_col   <= best_col;
    end
  end
`else
  assign max_score = '0;
  assign max_row   = '0;
  assign max_col   = '0;
`endif

endmodule

// File: tb/tb_sw_wavefront_array.sv
// Scoreboard bench for sw_wavefront_array: a 4x4 instance for the main scenarios and an
// 8x8 instance with 4-bit scores for saturation, both checked against a 2-D DP reference.
module tb_sw_wavefront_array;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4x4, 8-bit scores
  logic        start_a = 1'b0, ready_a = 1'b1;
  logic [7:0]  query_a = '0, db_a = '0;
  logic        busy_a, done_a, valid_a;
  logic [2:0]  diag_a;
  logic [3:0]  mask_a;
  logic [31:0] scores_a;
  logic [7:0]  src_a;
  logic [7:0]  maxs_a;
  logic [1:0]  maxr_a, maxc_a;

  // 8x8, 4-bit scores
  logic        start_b = 1'b0, ready_b = 1'b1;
  logic [15:0] query_b = '0, db_b = '0;
  logic        busy_b, done_b, valid_b;
  logic [3:0]  diag_b;
  logic [7:0]  mask_b;
  logic [31:0] scores_b;
  logic [15:0] src_b;
  logic [3:0]  maxs_b;
  logic [2:0]  maxr_b, maxc_b;

  sw_wavefront_array #(.NUM_PE(4), .DB_LENGTH(4), .SCORE_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .query_seq(query_a), .database_seq(db_a),
    .busy(busy_a), .done(done_a), .pkt_valid(valid_a), .pkt_ready(ready_a),
    .pkt_diag(diag_a), .pkt_mask(mask_a), .pkt_scores(scores_a), .pkt_src(src_a),
    .max_score(maxs_a), .max_row(maxr_a), .max_col(maxc_a));

  sw_wavefront_array #(.NUM_PE(8), .DB_LENGTH(8), .SCORE_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .query_seq(query_b), .database_seq(db_b),
    .busy(busy_b), .done(done_b), .pkt_valid(valid_b), .pkt_ready(ready_b),
    .pkt_diag(diag_b), .pkt_mask(mask_b), .pkt_scores(scores_b), .pkt_src(src_b),
    .max_score(maxs_b), .max_row(maxr_b), .max_col(maxc_b));

  typedef struct {
    int          diag;
    logic [63:0] mask;
    logic [63:0] scores;
    logic [63:0] src;
  } pkt_t;

  pkt_t qa[$];
  pkt_t qb[$];
  int n_tests = 0, n_fail = 0;
  int done_cnt_a = 0, done_cnt_b = 0, done_cyc = 0;
  int ea_score = 0, ea_row = 0, ea_col = 0, eb_score = 0;
  int mh[8][8];
  int msrc[8][8];
  int mmax, mrow, mcol;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Textbook local-alignment recurrence over the full matrix
  function automatic void ref_model(input int np, input int nd, input int sw,
                                    input int qv[8], input int dv[8]);
    int lim, dg, tp, lf, dt, tt, lt, h;
    lim = (1 << sw) - 1;
    for (int i = 0; i < np; i++)
      for (int j = 0; j < nd; j++) begin
        dg = (i > 0 && j > 0) ? mh[i-1][j-1] : 0;
        tp = (i > 0) ? mh[i-1][j] : 0;
        lf = (j > 0) ? mh[i][j-1] : 0;
        if (qv[i] == dv[j]) dt = (dg + 2 > lim) ? lim : dg + 2;
        else                dt = (dg - 1 < 0) ? 0 : dg - 1;
        tt = (tp - 1 < 0) ? 0 : tp - 1;
        lt = (lf - 1 < 0) ? 0 : lf - 1;
        h = dt;
        if (tt > h) h = tt;
        if (lt > h) h = lt;
        mh[i][j]   = h;
        msrc[i][j] = (h == 0) ? 0 : (h == dt) ? 1 : (h == tt) ? 2 : 3;
      end
    mmax = 0; mrow = 0; mcol = 0;
    for (int d = 0; d <= np + nd - 2; d++)
      for (int i = 0; i < np; i++)
        if (d - i >= 0 && d - i < nd && mh[i][d-i] > mmax) begin
          mmax = mh[i][d-i]; mrow = i; mcol = d - i;
        end
  endfunction

  task automatic push_exp(input int np, input int nd, input int sw, input bit to_b);
    pkt_t p;
    for (int d = 0; d <= np + nd - 2; d++) begin
      p.diag = d; p.mask = '0; p.scores = '0; p.src = '0;
      for (int i = 0; i < np; i++)
        if (d - i >= 0 && d - i < nd) begin
          p.mask[i]  = 1'b1;
          p.scores   = p.scores | (64'(mh[i][d-i]) << (i * sw));
          p.src      = p.src | (64'(msrc[i][d-i]) << (i * 2));
        end
      if (to_b) qb.push_back(p);
      else      qa.push_back(p);
    end
  endtask

  function automatic logic [15:0] pack_seq(input int v[8], input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*2 +: 2] = 2'(v[i]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_a) begin
        if (qa.size() == 0) chk("a_unexpected_pkt", 1, 0);
        else begin
          chk("a_diag", diag_a, qa[0].diag);
          chk("a_mask", mask_a, qa[0].mask);
          chk("a_scores", scores_a, qa[0].scores);
          chk("a_src", src_a, qa[0].src);
          if (ready_a) void'(qa.pop_front());
        end
      end
      if (done_a) begin
        done_cnt_a++;
        done_cyc = cyc;
        chk("a_pkts_left", qa.size(), 0);
        chk("a_max_score", maxs_a, ea_score);
        chk("a_max_row", maxr_a, ea_row);
        chk("a_max_col", maxc_a, ea_col);
      end
      if (valid_b) begin
        if (qb.size() == 0) chk("b_unexpected_pkt", 1, 0);
        else begin
          chk("b_diag", diag_b, qb[0].diag);
          chk("b_mask", mask_b, qb[0].mask);
          chk("b_scores", scores_b, qb[0].scores);
          chk("b_src", src_b, qb[0].src);
          if (ready_b) void'(qb.pop_front());
        end
      end
      if (done_b) begin
        done_cnt_b++;
        chk("b_pkts_left", qb.size(), 0);
        chk("b_max_score", maxs_b, eb_score);
      end
    end
  end

  // mode: 0 ready=1, 1 stall 5 cycles at d=arg, 2 random ready, 3 reset at d=arg, 4 start while busy at d=arg
  task automatic run_a(input int qv[8], input int dv[8], input int mode, input int arg);
    int dc0, stall, start_cyc;
    bit stalled, rst_hit, bs_done;
    ref_model(4, 4, 8, qv, dv);
    push_exp(4, 4, 8, 1'b0);
`ifdef SW_MAX_TRACK_EN
    ea_score = mmax; ea_row = mrow; ea_col = mcol;
`else
    ea_score = 0; ea_row = 0; ea_col = 0;
`endif
    dc0 = done_cnt_a;
    stall = 0; stalled = 0; rst_hit = 0; bs_done = 0;
    @(posedge clk); #2;
    query_a = 8'(pack_seq(qv, 4));
    db_a    = 8'(pack_seq(dv, 4));
    ready_a = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #2;
    start_a = 1'b0;
    start_cyc = cyc;
    chk("a_busy_after_start", busy_a, 1);
    for (int c = 0; c < 200 && done_cnt_a == dc0 && !rst_hit; c++) begin
      case (mode)
        1: begin
          if (stall > 0) begin
            stall--;
            if (stall == 0) ready_a = 1'b1;
          end else if (!stalled && valid_a && diag_a == 3'(arg)) begin
            ready_a = 1'b0; stall = 5; stalled = 1;
          end
        end
        2: ready_a = 1'($urandom_range(0, 1));
        3: if (valid_a && diag_a == 3'(arg)) begin
          rst_n = 1'b0; rst_hit = 1;
        end
        4: begin
          start_a = 1'b0;
          if (!bs_done && valid_a && diag_a == 3'(arg)) begin
            start_a = 1'b1; query_a = 8'($urandom); db_a = 8'($urandom); bs_done = 1;
          end
        end
        default: ready_a = 1'b1;
      endcase
      if (!rst_hit) begin
        @(posedge clk); #2;
      end
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    if (mode == 3) begin
      #1;
      chk("rst_busy", busy_a, 0);
      chk("rst_valid", valid_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_max", maxs_a, 0);
      chk("rst_hit", rst_hit, 1);
      qa.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      chk("rst_no_done", done_cnt_a - dc0, 0);
      chk("rst_idle_busy", busy_a, 0);
    end else begin
      repeat (3) @(posedge clk);
      #2;
      chk("a_done_count", done_cnt_a - dc0, 1);
      if (mode != 2 && done_cnt_a != dc0)
        chk("a_done_latency", done_cyc - start_cyc, 8 + ((mode == 1) ? 5 : 0));
      chk("a_busy_after_done", busy_a, 0);
      if (done_cnt_a == dc0) qa.delete();
    end
  endtask

  initial begin
    int qv[8], dv[8];
    int dc0;
    #1;
    chk("reset_busy", busy_a, 0);
    chk("reset_valid", valid_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_diag", diag_a, 0);
    chk("reset_scores", scores_a, 0);
    chk("reset_max", maxs_a, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin qv[i] = i % 4; dv[i] = i % 4; end
    run_a(qv, dv, 0, 0);
    run_a(qv, dv, 1, 2);
    run_a(qv, dv, 3, 3);
    run_a(qv, dv, 0, 0);
    run_a(qv, dv, 4, 1);

    for (int i = 0; i < 8; i++) begin qv[i] = 0; dv[i] = 1; end
    run_a(qv, dv, 0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) begin
        qv[i] = $urandom_range(0, 3);
        dv[i] = $urandom_range(0, 3);
      end
      run_a(qv, dv, (r % 2 == 0) ? 2 : 0, 0);
    end

    // Saturation on the 8x8 instance with 4-bit scores
    for (int i = 0; i < 8; i++) begin qv[i] = i % 4; dv[i] = i % 4; end
    ref_model(8, 8, 4, qv, dv);
    push_exp(8, 8, 4, 1'b1);
    chk("b_model_h77_saturates", mh[7][7], 15);
`ifdef SW_MAX_TRACK_EN
    eb_score = mmax;
`else
    eb_score = 0;
`endif
    dc0 = done_cnt_b;
    @(posedge clk); #2;
    query_b = pack_seq(qv, 8);
    db_b    = pack_seq(dv, 8);
    start_b = 1'b1;
    @(posedge clk); #2;
    start_b = 1'b0;
    for (int c = 0; c < 100 && done_cnt_b == dc0; c++) begin
      @(posedge clk); #2;
    end
    chk("b_done_count", done_cnt_b - dc0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sw_wavefront_array.md
Name: sw_wavefront_array

Overview:
- Parametrised linear systolic Smith-Waterman score engine. The next generation of the matrix-fill datapath.
- Computes the full H matrix one anti-diagonal per advance: one query letter per PE, database letters indexed per diagonal.
- Owns its wavefront counter and start/done sequencing; no external global counter.
- Streams per-diagonal score/source packets to matrix memory over valid/ready and tracks the best local score.

Parameters:
- NUM_PE, 16, query length; one PE per query letter (row).
- DB_LENGTH, 16, database length (columns), >=1.
- LETTER_WIDTH, 2, letter encoding width.
- SCORE_WIDTH, 8, unsigned score width.
- MATCH, 2, added on letter equality.
- MISMATCH, 1, subtracted on inequality.
- GAP, 1, subtracted for a top/left move.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; latches sequences, begins a run when idle.
- query_seq  in  NUM_PE*LETTER_WIDTH  query; letter i = row i.
- database_seq  in  DB_LENGTH*LETTER_WIDTH  database; letter j = column j.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- pkt_valid  out  1  diagonal packet available.
- pkt_ready  in  1  consumer accepts packet.
- pkt_diag  out  $clog2(NUM_PE+DB_LENGTH)  anti-diagonal index d.
- pkt_mask  out  NUM_PE  bit i = PE i holds a real cell on d.
- pkt_scores  out  NUM_PE*SCORE_WIDTH  H(i, d-i); 0 where masked.
- pkt_src  out  NUM_PE*2  source: 00 zero, 01 diag, 10 top, 11 left.
- max_score  out  SCORE_WIDTH  best H of run.
- max_row  out  $clog2(NUM_PE)  row of best H.
- max_col  out  $clog2(DB_LENGTH)  column of best H.

Behaviour:
- Reset: all outputs 0; FSM IDLE; internal H/diag registers 0.
- FSM IDLE: start latches query_seq/database_seq, clears PE registers and max, sets d=0, goes to RUN; busy=1 from the next cycle.
- FSM RUN: advance = !pkt_valid || pkt_ready.
  - On advance: compute diagonal d and register the packet (pkt_valid=1, pkt_diag=d); d++.
  - After d = NUM_PE+DB_LENGTH-2 is registered, go to FLUSH.
- FSM FLUSH: wait for the handshake of the last packet, then pulse done, drop busy and pkt_valid, and return to IDLE.
- Latency: with pkt_ready=1, diagonal d is presented 1+d cycles after the start edge. done is 1 cycle after the last handshake.
- Total packets per run: NUM_PE+DB_LENGTH-1.
- PE i at diagonal d is active iff 0 <= d-i < DB_LENGTH, with j = d-i.
  - top = PE i-1 output at d-1.
  - diag = PE i-1 output at d-2.
  - left = own output at d-1.
  - PE 0 uses top = diag = 0. Left is 0 at j=0 because of the start clear.
- Cell: H = max(0, diag+s, top-GAP, left-GAP), where s = +MATCH or -MISMATCH.
  - Subtraction floors at 0.
  - Addition saturates at 2^SCORE_WIDTH-1.
  - Inactive PEs output H=0 and src=00.
- Source tie priority: diag > top > left; H=0 gives src=00.
- Backpressure: while pkt_valid && !pkt_ready, the whole array and d hold, and packet outputs stay stable.
- start while busy: ignored.
- rst_n asserted mid-run: immediate return to IDLE, all outputs 0, no done.

Optional Feature:
- Macro: SW_MAX_TRACK_EN.
- Defined: on each advance, max_score/max_row/max_col update only on a strictly greater active H.
  - Ties keep the earliest value: lowest d, then lowest row.
  - Values are cleared on start and held after done until the next start.
- Undefined: max_* tied to 0 and no compare logic.

Test Plan:
- Identical sequences: NUM_PE=4, DB_LENGTH=4, query=database=0,1,2,3, pkt_ready=1.
  - Expect 7 packets, d=0..6.
  - Main diagonal H = 2,4,6,8 with src=01.
  - With the macro: max_score=8, max_row=3, max_col=3. done 1 cycle after packet d=6.
- All mismatch: query all 0, database all 1.
  - Expect every pkt_scores=0 and pkt_src=00.
  - Masks 0001, 0011, 0111, 1111, 1110, 1100, 1000. max_score=0.
- Saturation: SCORE_WIDTH=4, NUM_PE=DB_LENGTH=8, identical sequences.
  - Expect H(7,7)=15, not 16. max_score=15.
- Backpressure: hold pkt_ready=0 for 5 cycles at d=2.
  - Expect pkt_diag=2 and scores stable; no d skipped; total packets still 7; done delayed 5 cycles.
- Reset and restart: assert rst_n=0 at d=3.
  - Expect busy=0, pkt_valid=0, max=0, no done.
  - A new start then reproduces the identical-sequence result exactly.
- Busy start: pulse start at d=1 of a run.
  - Expect it ignored: sequences unchanged and a single done.
